// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial sequencer sharing one byte-wide RAM port between instruction fetch and load/store.
// Optional MEM_CTRL_RR_ARB_EN: round-robin IF/MEM tie breaking instead of fixed MEM priority.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_busy_o,
  output logic [31:0]       if_data_o,
  input  logic [2:0]        read_i,
  input  logic [1:0]        write_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              read_busy_o,
  output logic              write_busy_o,
  output logic [31:0]       read_data_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_W  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        rtype_q, rtype_d;
  logic              owner_if_q, owner_if_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              if_done_q, if_done_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;

  logic              mem_req;
  logic              grant_if;
  logic [2:0]        cnt_nxt;
  logic [1:0]        cap_idx;
  logic [31:0]       asm_word;

  function automatic logic [2:0] rd_len(input logic [2:0] t);
    logic [2:0] n;
    case (t)
      LD_B, LD_BU: n = 3'd1;
      LD_H, LD_HU: n = 3'd2;
      default:     n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] wr_len(input logic [1:0] t);
    logic [2:0] n;
    case (t)
      2'd1:    n = 3'd1;
      2'd2:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] w);
    logic [31:0] r;
    case (t)
      LD_B:    r = {{24{w[7]}}, w[7:0]};
      LD_H:    r = {{16{w[15]}}, w[15:0]};
      LD_BU:   r = {24'd0, w[7:0]};
      LD_HU:   r = {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign mem_req = (read_i != 3'd0) || (write_i != 2'd0);

`ifdef MEM_CTRL_RR_ARB_EN
  logic last_if_q, last_if_d;

  // Remember who won the last grant so a tie goes to the other requester.
  always_comb begin
    last_if_d = last_if_q;
    if (state_q == IDLE && (if_req_i || mem_req)) begin
      last_if_d = grant_if;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_if_q <= 1'b1;
    else     last_if_q <= last_if_d;
  end

  assign grant_if = if_req_i && (!mem_req || !last_if_q);
`else
  assign grant_if = if_req_i && !mem_req;
`endif

  assign cnt_nxt  = cnt_q + 3'd1;
  assign cap_idx  = cnt_q[1:0] - 2'd1;

  // RAM data lags its address by one cycle, so RD cycle c captures byte c-1.
  always_comb begin
    asm_word = rbuf_q;
    asm_word[{cap_idx, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rtype_d     = rtype_q;
    owner_if_d  = owner_if_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    read_data_d = read_data_q;
    if_done_d   = 1'b0;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (grant_if) begin
          owner_if_d = 1'b1;
          addr_d     = if_addr_i[ADDR_W-1:0];
          rtype_d    = LD_W;
          len_d      = 3'd4;
          ram_a_d    = if_addr_i[ADDR_W-1:0];
          state_d    = RD;
        end else if (read_i != 3'd0) begin
          owner_if_d = 1'b0;
          addr_d     = addr_i[ADDR_W-1:0];
          rtype_d    = read_i;
          len_d      = rd_len(read_i);
          ram_a_d    = addr_i[ADDR_W-1:0];
          state_d    = RD;
        end else if (write_i != 2'd0) begin
          owner_if_d = 1'b0;
          addr_d     = addr_i[ADDR_W-1:0];
          wdata_d    = wdata_i;
          len_d      = wr_len(write_i);
          ram_a_d    = addr_i[ADDR_W-1:0];
          ram_dout_d = wdata_i[7:0];
          ram_wr_d   = 1'b1;
          state_d    = WR;
        end
      end

      RD: begin
        cnt_d = cnt_nxt;
        if (cnt_q != 3'd0) rbuf_d = asm_word;
        if (cnt_nxt < len_q) ram_a_d = addr_q + ADDR_W'(cnt_nxt);
        if (cnt_q == len_q) begin
          state_d = DONE;
          if (owner_if_q) begin
            if_data_d = asm_word;
            if_done_d = 1'b1;
          end else begin
            read_data_d = extend(rtype_q, asm_word);
            rd_done_d   = 1'b1;
          end
        end
      end

      WR: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt < len_q) begin
          ram_a_d    = addr_q + ADDR_W'(cnt_nxt);
          ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          state_d   = DONE;
          wr_done_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      rtype_q     <= 3'd0;
      owner_if_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= 32'd0;
      read_data_q <= 32'd0;
      if_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rtype_q     <= rtype_d;
      owner_if_q  <= owner_if_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      read_data_q <= read_data_d;
      if_done_q   <= if_done_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign if_busy_o    = if_req_i && !if_done_q;
  assign read_busy_o  = (read_i != 3'd0) && !rd_done_q;
  assign write_busy_o = (write_i != 2'd0) && !wr_done_q;
  assign if_data_o    = if_data_q;
  assign read_data_o  = read_data_q;
  assign ram_a_o      = ram_a_q;
  assign ram_dout_o   = ram_dout_q;
  assign ram_wr_o     = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a transaction-level model schedules grants and
// predicts busy flags, RAM traffic and result words for directed and random requests.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_busy_o;
  logic [31:0] if_data_o;
  logic [2:0]  read_i;
  logic [1:0]  write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        read_busy_o;
  logic        write_busy_o;
  logic [31:0] read_data_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_busy_o(if_busy_o), .if_data_o(if_data_o),
    .read_i(read_i), .write_i(write_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .read_busy_o(read_busy_o), .write_busy_o(write_busy_o), .read_data_o(read_data_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h100:   return 8'h78;
      'h101:   return 8'h56;
      'h102:   return 8'h34;
      'h103:   return 8'h12;
      'h200:   return 8'h80;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // 1 KB RAM with one-cycle read latency; upper address bits alias.
  logic [7:0] ram [0:1023];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (ram_wr_o) begin
      ram[ram_a_o[9:0]] <= ram_dout_o;
    end
    ram_din_i <= ram[ram_a_o[9:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction model: grant list with start (IDLE) cycle, done cycle and payload.
  typedef struct {
    int          owner;
    int          t;
    int          d;
    logic [31:0] addr;
    int          n;
    logic [31:0] data;
  } grant_t;

  grant_t     g [8];
  int         ng = 0;
  logic [7:0] model_mem [0:1023];
  bit         model_last_if = 1'b1;
  bit         mon_en = 1'b0;
  logic [31:0] exp_if_data = 32'd0;
  logic [31:0] exp_read_data = 32'd0;

  function automatic int rd_bytes(input int rt);
    if (rt == 1 || rt == 4) return 1;
    if (rt == 2 || rt == 5) return 2;
    return 4;
  endfunction

  function automatic int wr_bytes(input int wt);
    if (wt == 1) return 1;
    if (wt == 2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input int rt, input logic [31:0] a);
    longint      u;
    logic [31:0] ak;
    u = 0;
    for (int k = rd_bytes(rt) - 1; k >= 0; k--) begin
      ak = a + 32'(k);
      u  = u * 256 + longint'(model_mem[ak[9:0]]);
    end
    if (rt == 1 && u >= 128)   u = u - 256;
    if (rt == 2 && u >= 32768) u = u - 65536;
    return 32'(u);
  endfunction

  task automatic model_store(input int wt, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] ak;
    for (int k = 0; k < wr_bytes(wt); k++) begin
      ak = a + 32'(k);
      model_mem[ak[9:0]] = 8'((wd >> (8 * k)) & 255);
    end
  endtask

  // Schedule a batch of simultaneous requests (counts >1 mean the request is held
  // for that many services), then drive it, dropping each requester after its last done.
  task automatic applyStimulus(input int ic, input logic [31:0] ia, input int rt, input int rc,
                               input int wt, input int wc, input logic [31:0] a,
                               input logic [31:0] wd);
    int pi, pr, pw, t, own, n, lat, k, d_if, d_rd, d_wr, last_d;
    bit mem;
    @(posedge clk); #1;
    pi = ic; pr = rc; pw = wc; t = cyc; k = 0;
    d_if = -10; d_rd = -10; d_wr = -10;
    ng = 0;
    while (pi > 0 || pr > 0 || pw > 0) begin
      mem = (pr > 0) || (pw > 0);
`ifdef MEM_CTRL_RR_ARB_EN
      if (pi > 0 && (!mem || !model_last_if)) own = 0;
`else
      if (pi > 0 && !mem) own = 0;
`endif
      else if (pr > 0) own = 1;
      else own = 2;
      model_last_if = (own == 0);
      g[k].owner = own;
      g[k].t     = t;
      if (own == 0) begin
        n = 4; lat = n + 2;
        g[k].addr = ia; g[k].data = model_load(3, ia);
        pi--; d_if = t + lat;
      end else if (own == 1) begin
        n = rd_bytes(rt); lat = n + 2;
        g[k].addr = a; g[k].data = model_load(rt, a);
        pr--; d_rd = t + lat;
      end else begin
        n = wr_bytes(wt); lat = n + 1;
        g[k].addr = a; g[k].data = wd;
        model_store(wt, a, wd);
        pw--; d_wr = t + lat;
      end
      g[k].n = n;
      g[k].d = t + lat;
      t = t + lat + 1;
      k++;
    end
    ng = k;
    if_req_i  = (ic > 0);
    if_addr_i = ia;
    read_i    = (rc > 0) ? 3'(rt) : 3'd0;
    write_i   = (wc > 0) ? 2'(wt) : 2'd0;
    addr_i    = a;
    wdata_i   = wd;
    last_d = d_if;
    if (d_rd > last_d) last_d = d_rd;
    if (d_wr > last_d) last_d = d_wr;
    while (cyc <= last_d) begin
      @(posedge clk); #1;
      if (cyc == d_if + 1) if_req_i = 1'b0;
      if (cyc == d_rd + 1) read_i = 3'd0;
      if (cyc == d_wr + 1) write_i = 2'd0;
    end
  endtask

  // Per-cycle comparison of every observable output against the grant schedule.
  task automatic checkOutput();
    bit          eib, erb, ewb, ew, ca;
    logic [31:0] ea, ed;
    int          k;
    eib = if_req_i; erb = (read_i != 3'd0); ewb = (write_i != 2'd0);
    ew = 1'b0; ca = 1'b0; ea = 32'd0; ed = 32'd0;
    for (int i = 0; i < ng; i++) begin
      if (cyc == g[i].d) begin
        if (g[i].owner == 0) begin eib = 1'b0; exp_if_data = g[i].data; end
        else if (g[i].owner == 1) begin erb = 1'b0; exp_read_data = g[i].data; end
        else ewb = 1'b0;
      end
      if (cyc > g[i].t && cyc <= g[i].t + g[i].n) begin
        k  = cyc - g[i].t - 1;
        ca = 1'b1;
        ea = g[i].addr + 32'(k);
        if (g[i].owner == 2) begin
          ew = 1'b1;
          ed = (g[i].data >> (8 * k)) & 32'hFF;
        end
      end
    end
    chk("if_busy", 32'(if_busy_o), 32'(eib));
    chk("read_busy", 32'(read_busy_o), 32'(erb));
    chk("write_busy", 32'(write_busy_o), 32'(ewb));
    chk("if_data", if_data_o, exp_if_data);
    chk("read_data", read_data_o, exp_read_data);
    chk("ram_wr", 32'(ram_wr_o), 32'(ew));
    if (ca) chk("ram_a", ram_a_o, ea);
    if (ew) chk("ram_dout", {24'd0, ram_dout_o}, ed);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_if_data   = 32'd0;
      exp_read_data = 32'd0;
    end else if (mon_en) begin
      checkOutput();
    end
  end

  initial begin
    int exp_own [4];
    int bad;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0; read_i = 3'd0; write_i = 2'd0;
    addr_i = 32'd0; wdata_i = 32'd0;
    for (int i = 0; i < 1024; i++) model_mem[i] = init_byte(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    $display("[TB] reset released");
    chk("reset_ram_a", ram_a_o, 32'd0);
    chk("reset_ram_wr", 32'(ram_wr_o), 32'd0);
    chk("reset_ram_dout", {24'd0, ram_dout_o}, 32'd0);
    chk("reset_if_data", if_data_o, 32'd0);
    chk("reset_read_data", read_data_o, 32'd0);
    mon_en = 1'b1;

    applyStimulus(0, 32'd0, 3, 1, 0, 0, 32'h100, 32'd0);
    chk("lw_model_data", g[0].data, 32'h12345678);
    chk("lw_model_latency", 32'(g[0].d - g[0].t), 32'd6);
    chk("lw_result", read_data_o, 32'h12345678);

    applyStimulus(0, 32'd0, 1, 1, 0, 0, 32'h200, 32'd0);
    chk("lb_model_data", g[0].data, 32'hFFFFFF80);
    chk("lb_model_latency", 32'(g[0].d - g[0].t), 32'd3);
    chk("lb_result", read_data_o, 32'hFFFFFF80);

    applyStimulus(0, 32'd0, 4, 1, 0, 0, 32'h200, 32'd0);
    chk("lbu_result", read_data_o, 32'h00000080);

    applyStimulus(0, 32'd0, 0, 0, 2, 1, 32'h300, 32'hAABBCCDD);
    chk("sh_model_latency", 32'(g[0].d - g[0].t), 32'd3);
    chk("sh_ram0", {24'd0, ram[10'h300]}, 32'hDD);
    chk("sh_ram1", {24'd0, ram[10'h301]}, 32'hCC);
    chk("sh_ram2", {24'd0, ram[10'h302]}, {24'd0, init_byte('h302)});

    applyStimulus(1, 32'h100, 3, 1, 0, 0, 32'h100, 32'd0);
    chk("if_lw_first_owner", 32'(g[0].owner), 32'd1);
    chk("if_lw_fetch_gap", 32'(g[1].d - g[0].d), 32'd7);
    chk("if_lw_fetch_word", if_data_o, 32'h12345678);

    applyStimulus(2, 32'h200, 3, 2, 0, 0, 32'h100, 32'd0);
`ifdef MEM_CTRL_RR_ARB_EN
    exp_own = '{1, 0, 1, 0};
`else
    exp_own = '{1, 1, 0, 0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("held_grant%0d", i), 32'(g[i].owner), 32'(exp_own[i]));

    // Reset in the middle of a word store, while byte 2 is on the bus.
    mon_en = 1'b0;
    ng = 0;
    @(posedge clk); #1;
    write_i = 2'd3; addr_i = 32'h340; wdata_i = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    chk("sw_byte2_wr", 32'(ram_wr_o), 32'd1);
    chk("sw_byte2_a", ram_a_o, 32'h342);
    rst = 1'b1;
    #1;
    chk("rst_wr_drop", 32'(ram_wr_o), 32'd0);
    chk("rst_ram_a", ram_a_o, 32'd0);
    chk("rst_write_busy", 32'(write_busy_o), 32'd1);
    write_i = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last_if = 1'b1;
    model_mem[10'h340] = 8'h44;
    model_mem[10'h341] = 8'h33;
    chk("rst_sw_ram0", {24'd0, ram[10'h340]}, 32'h44);
    chk("rst_sw_ram1", {24'd0, ram[10'h341]}, 32'h33);
    chk("rst_sw_ram2", {24'd0, ram[10'h342]}, {24'd0, init_byte('h342)});
    chk("rst_sw_ram3", {24'd0, ram[10'h343]}, {24'd0, init_byte('h343)});
    mon_en = 1'b1;
    applyStimulus(0, 32'd0, 3, 1, 0, 0, 32'h340, 32'd0);
    chk("post_rst_lw", read_data_o, {init_byte('h343), init_byte('h342), 8'h33, 8'h44});

    for (int b = 0; b < 150; b++) begin
      int ic, rt, rc, wt, wc;
      logic [31:0] ia, a, wd;
      ic = int'($urandom_range(0, 1));
      rc = int'($urandom_range(0, 1));
      wc = ($urandom_range(0, 9) < 4) ? 1 : 0;
      if (ic == 0 && rc == 0 && wc == 0) rc = 1;
      if ($urandom_range(0, 7) == 0) begin
        if (ic > 0) ic = 2;
        if (rc > 0) rc = 2;
      end
      rt = int'($urandom_range(1, 5));
      wt = int'($urandom_range(1, 3));
      ia = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 1023));
      a  = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 1023));
      wd = $urandom();
      applyStimulus(ic, ia, rt, rc, wt, wc, a, wd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    mon_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== model_mem[i]) bad++;
    chk("ram_contents_mismatched_bytes", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sequences the single byte-wide RAM port and shares it between two requesters: instruction fetch (IF) and the load/store stage (MEM).
- Breaks 8/16/32-bit accesses into little-endian byte transfers, assembles and extends read data, and drives per-requester busy flags that the stages use to stall.
- Sits between the IF/MEM pipeline stages and the external RAM.

Parameters:
ADDR_W, 32, width of ram_a_o; request addresses are truncated to the low ADDR_W bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
if_req_i  input  1  IF fetch request, held until done
if_addr_i  input  32  fetch address
if_busy_o  output  1  IF request pending, not completing this cycle
if_data_o  output  32  fetched instruction word, valid in the IF done cycle
read_i  input  3  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
write_i  input  2  store type: 0 none, 1 SB, 2 SH, 3 SW
addr_i  input  32  load/store address
wdata_i  input  32  store data
read_busy_o  output  1  load pending, not completing this cycle
write_busy_o  output  1  store pending, not completing this cycle
read_data_o  output  32  extended load result, valid in the load done cycle
ram_din_i  input  8  RAM read byte; returns 1 cycle after its address
ram_dout_o  output  8  RAM write byte
ram_a_o  output  ADDR_W  RAM byte address
ram_wr_o  output  1  RAM write strobe, 1 = write

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - ram_a_o, ram_dout_o and ram_wr_o are 0.
  - if_data_o and read_data_o are 0.
  - Byte counter and done flags are cleared.
  - An access in flight is aborted with no partial completion.
- Busy flags are combinational:
  - if_busy_o = if_req_i & ~if_done
  - read_busy_o = (read_i!=0) & ~rd_done
  - write_busy_o = (write_i!=0) & ~wr_done
- Done flags are registered one-cycle pulses.
- States: IDLE, RD, WR, DONE.
- IDLE: samples requests each cycle. Grant order:
  - A MEM load or store wins over IF.
  - If read_i and write_i are both nonzero, the read is served and the write waits.
  - On grant, latch address, type, store data and owner; set N = 1, 2 or 4 bytes; go to RD or WR.
- RD: byte k address (addr+k) is driven in RD cycle k+1 with ram_wr_o = 0.
  - ram_din_i is captured in the following cycle.
  - After the last address, one extra capture cycle is spent, then the result is registered and the state goes to DONE.
- WR: byte k is driven in WR cycle k+1 with ram_wr_o = 1, ram_a_o = addr+k and ram_dout_o = wdata[8k+7:8k]. After byte N-1, go to DONE.
- DONE (one cycle):
  - Pulse the owner's done flag, so its busy is low this cycle.
  - Load: read_data_o is updated. Fetch: if_data_o is updated.
  - Next state is IDLE.
  - Outside DONE, if_data_o and read_data_o hold their last values.
- Latency, counted from the request seen in IDLE at cycle 0:
  - LW and fetch: done at cycle 6.
  - LH/LHU: done at cycle 4.
  - LB/LBU: done at cycle 3.
  - SW: done at cycle 5. SH: cycle 3. SB: cycle 2.
- Extension:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - Fetch is always a 32-bit word.
- Outside WR, ram_wr_o = 0. Outside RD/WR, ram_a_o holds its last value.
- Requester contract:
  - Inputs stay stable while busy.
  - In the cycle after done, the requester must drop or change its request; a request still present in IDLE is treated as new.
- No alignment check: any address is accepted, and a byte address wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: MEM_CTRL_RR_ARB_EN.
- Defined: on simultaneous IF and MEM requests in IDLE, grant goes to the requester not served by the previous grant. The last-served flag resets to IF, so MEM wins the first tie.
- Undefined: fixed priority, MEM always wins.

Test Plan:
- Preload RAM[0x100..0x103] = 78 56 34 12; LW 0x100 -> read_busy_o high cycles 0-5, low at cycle 6 with read_data_o = 0x12345678; ram_wr_o never 1.
- LB and LBU at 0x200 holding 0x80 -> LB gives 0xFFFFFF80 (done cycle 3); LBU gives 0x00000080.
- SH addr 0x300, wdata 0xAABBCCDD -> RAM[0x300] = DD and RAM[0x301] = CC on cycles 1-2; done cycle 3; RAM[0x302] unchanged.
- IF and LW requested together in the same cycle -> load served first; if_busy_o stays high until the fetch's done 7 cycles after load done; if_data_o is correct.
- rst pulsed mid-SW, after byte 1 -> ram_wr_o drops immediately; no done pulse; only bytes 0-1 are written; the next request behaves normally.
- With MEM_CTRL_RR_ARB_EN and both requesters held continuously -> grants alternate MEM, IF, MEM. Without it -> MEM wins every tie.
